dual_port_ram_param: RTL and testbench
======================================

# dual_port_ram_param

Parametrised true dual-port synchronous RAM; the next generation of the fabric's 8-bit x 1024 dual-port block RAM primitive. Adds configurable width and depth, byte-lane write enables, per-port read enable, selectable read-during-write behaviour, an optional output pipeline register, read-valid strobes and cross-port collision reporting. Used as the simulation and synthesis model for the eFPGA BRAM tile and mapped by the yosys flow.

## Interface

- DATA_WIDTH, 8: word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 10: address width; depth = 2**ADDR_WIDTH words.
- BYTE_WIDTH, 8: bits per write-enable lane; NUM_BE = DATA_WIDTH/BYTE_WIDTH.
- RDW_MODE, 2: same-port read-during-write. 0 = read-first (old data), 1 = write-first (new merged word), 2 = no-change (d_out holds, no valid).
- OUT_REG, 0: 1 adds an output pipeline register on both ports.

Ports (n = 1, 2). All vectors use ascending ranges [0:W-1]; byte lane k = bits [k*BYTE_WIDTH : k*BYTE_WIDTH+BYTE_WIDTH-1], be bit k controls lane k.

- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high.
- en_n  input  1  port enable; no access when low.
- wen_n  input  1  write (1) / read (0) when en_n high.
- be_n  input  NUM_BE  byte-lane write enables, ignored on reads.
- addr_n  input  ADDR_WIDTH  word address.
- d_in_n  input  DATA_WIDTH  write data.
- d_out_n  output  DATA_WIDTH  read data.
- valid_n  output  1  one-cycle strobe: d_out_n updated with a new read result.
- collision  output  1  one-cycle strobe: both ports accessed the same address in a cycle with at least one writing.

## Operation

- Access cycle = rising clk with reset low and en_n high. Write: lanes with be_n[k]=1 updated, others unchanged. Read: the addressed word is captured.
- d_out_n holds its last value between reads; it never changes without valid_n.
- Same-port write (wen_n=1): RDW_MODE 0: d_out_n = pre-write word, valid_n pulses. RDW_MODE 1: d_out_n = post-write merged word, valid_n pulses. RDW_MODE 2: d_out_n unchanged, valid_n low.
- Cross-port, same address: a reading port always gets the pre-write word (read-first across ports), independent of RDW_MODE.
- Both ports write the same address: lanes enabled on port 1 take d_in_1; lanes enabled only on port 2 take d_in_2; port 1 wins on overlap.
- collision asserts for any same-address access where at least one port writes; both-read to the same address is not a collision.
- Memory contents are not initialised and not cleared by reset; simulation contents before first write are X.
- en_n low: no memory access, no valid_n, no effect on collision.

## Timing

- Reset values: d_out_1 = d_out_2 = 0, valid_1 = valid_2 = 0, collision = 0; pipeline stage (OUT_REG=1) cleared to 0 with its valid bit cleared.
- Read latency: OUT_REG=0: data and valid_n after the access edge (cycle N access -> visible in N+1). OUT_REG=1: visible in N+2; back-to-back reads every cycle sustain full throughput.
- collision registered: visible in the cycle after the offending access, one cycle wide per offending access, independent of OUT_REG.
- Reset mid-operation: outputs clear immediately (asynchronously); in-flight reads in the pipeline are discarded and never produce valid_n; an access on the edge where reset is high is dropped (no write). First valid access is on the first edge with reset low.
- Address wrap: addr_n spans the full depth; no out-of-range condition exists.

## Test plan

- Reset then port 1 writes 0xA5C3 to addr 0x3FF (DATA_WIDTH 16, be=2'b11); port 2 reads 0x3FF next cycle -> d_out_2=0xA5C3, valid_2 high exactly one cycle at N+1 (OUT_REG=0) / N+2 (OUT_REG=1).
- Byte enables: word 0x1234 at addr 5, port 1 writes 0xFFFF with be=2'b01 -> read returns 0x12FF.
- RDW_MODE sweep: addr 7 holds 0x0011, port 1 writes 0x2233 with read: mode 0 -> d_out_1=0x0011 valid; mode 1 -> 0x2233 valid; mode 2 -> d_out_1 unchanged, valid_1 low.
- Same-address dual write: port 1 writes 0xAAAA be=2'b10, port 2 writes 0x5555 be=2'b11 to addr 9 -> memory 0xAA55, collision high one cycle later for one cycle; port 2 reading while port 1 writes -> old data, collision high.
- Both ports read addr 3 same cycle -> both valid, identical data, collision stays low.
- Assert reset in the cycle after a read issue with OUT_REG=1 -> d_out/valid go 0 immediately, no valid after release; memory contents previously written still read back correctly.

Source files
------------

// File: rtl/dual_port_ram_param.sv
// Parametrised true dual-port synchronous RAM with byte-lane writes, selectable
// same-port read-during-write, optional output register and collision strobe.
module dual_port_ram_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int BYTE_WIDTH = 8,
  parameter int RDW_MODE   = 2,
  parameter int OUT_REG    = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en_1,
  input  logic                             wen_1,
  input  logic [0:DATA_WIDTH/BYTE_WIDTH-1] be_1,
  input  logic [0:ADDR_WIDTH-1]            addr_1,
  input  logic [0:DATA_WIDTH-1]            d_in_1,
  output logic [0:DATA_WIDTH-1]            d_out_1,
  output logic                             valid_1,
  input  logic                             en_2,
  input  logic                             wen_2,
  input  logic [0:DATA_WIDTH/BYTE_WIDTH-1] be_2,
  input  logic [0:ADDR_WIDTH-1]            addr_2,
  input  logic [0:DATA_WIDTH-1]            d_in_2,
  output logic [0:DATA_WIDTH-1]            d_out_2,
  output logic                             valid_2,
  output logic                             collision
);

  localparam int         NUM_BE  = DATA_WIDTH / BYTE_WIDTH;
  localparam int         DEPTH   = 32'd1 << ADDR_WIDTH;
  localparam logic [1:0] RDW_SEL = RDW_MODE[1:0];

  logic                  en_s   [2];
  logic                  wen_s  [2];
  logic                  wr_s   [2];
  logic [0:NUM_BE-1]     be_s   [2];
  logic [0:ADDR_WIDTH-1] addr_s [2];
  logic [0:DATA_WIDTH-1] din_s  [2];
  logic [0:DATA_WIDTH-1] old_s  [2];
  logic [0:DATA_WIDTH-1] post_s [2];
  logic [0:DATA_WIDTH-1] dout_s [2];
  logic                  vld_s  [2];
  logic                  same_addr_s;
  logic                  collision_r;
  logic [0:DATA_WIDTH-1] mem_r  [DEPTH];

  assign en_s[0]   = en_1;
  assign en_s[1]   = en_2;
  assign wen_s[0]  = wen_1;
  assign wen_s[1]  = wen_2;
  assign be_s[0]   = be_1;
  assign be_s[1]   = be_2;
  assign addr_s[0] = addr_1;
  assign addr_s[1] = addr_2;
  assign din_s[0]  = d_in_1;
  assign din_s[1]  = d_in_2;
  assign wr_s[0]   = en_1 & wen_1 & ~reset;
  assign wr_s[1]   = en_2 & wen_2 & ~reset;

  // Post-write word per port; at a shared address both ports see the same
  // merged word, port 1 lanes taking priority over port 2 lanes.
  always_comb begin
    same_addr_s = (addr_s[0] == addr_s[1]);
    for (int p = 0; p < 2; p++) begin
      old_s[p]  = mem_r[addr_s[p]];
      post_s[p] = old_s[p];
      for (int k = 0; k < NUM_BE; k++) begin
        if (wr_s[0] && be_s[0][k] && ((p == 0) || same_addr_s)) begin
          post_s[p][k*BYTE_WIDTH +: BYTE_WIDTH] = din_s[0][k*BYTE_WIDTH +: BYTE_WIDTH];
        end else if (wr_s[1] && be_s[1][k] && ((p == 1) || same_addr_s)) begin
          post_s[p][k*BYTE_WIDTH +: BYTE_WIDTH] = din_s[1][k*BYTE_WIDTH +: BYTE_WIDTH];
        end else begin
          post_s[p][k*BYTE_WIDTH +: BYTE_WIDTH] = old_s[p][k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Storage is never reset; identical words land when both ports share an address.
  always_ff @(posedge clk) begin
    if (wr_s[1]) begin
      mem_r[addr_s[1]] <= post_s[1];
    end
    if (wr_s[0]) begin
      mem_r[addr_s[0]] <= post_s[0];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                  fire_s;
    logic [0:DATA_WIDTH-1] word_s;
    logic [0:DATA_WIDTH-1] s1_data_r;
    logic                  s1_valid_r;

    // Result selection: other-port writes never affect this port's read word.
    always_comb begin
      fire_s = 1'b0;
      word_s = old_s[p];
      if (en_s[p] && wen_s[p]) begin
        case (RDW_SEL)
          2'd0:    begin fire_s = 1'b1; word_s = old_s[p];  end
          2'd1:    begin fire_s = 1'b1; word_s = post_s[p]; end
          default: begin fire_s = 1'b0; word_s = old_s[p];  end
        endcase
      end else begin
        fire_s = en_s[p];
        word_s = old_s[p];
      end
    end

    // First output stage: data only moves together with its valid strobe.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_data_r  <= '0;
        s1_valid_r <= 1'b0;
      end else begin
        s1_valid_r <= fire_s;
        if (fire_s) begin
          s1_data_r <= word_s;
        end
      end
    end

    if (OUT_REG != 0) begin : g_oreg
      logic [0:DATA_WIDTH-1] s2_data_r;
      logic                  s2_valid_r;

      // Optional pipeline stage; reset discards whatever is in flight.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s2_data_r  <= '0;
          s2_valid_r <= 1'b0;
        end else begin
          s2_valid_r <= s1_valid_r;
          if (s1_valid_r) begin
            s2_data_r <= s1_data_r;
          end
        end
      end

      assign dout_s[p] = s2_data_r;
      assign vld_s[p]  = s2_valid_r;
    end else begin : g_direct
      assign dout_s[p] = s1_data_r;
      assign vld_s[p]  = s1_valid_r;
    end
  end

  // Same-address access with at least one writer, flagged one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      collision_r <= 1'b0;
    end else begin
      collision_r <= en_1 & en_2 & same_addr_s & (wen_1 | wen_2);
    end
  end

  assign d_out_1   = dout_s[0];
  assign d_out_2   = dout_s[1];
  assign valid_1   = vld_s[0];
  assign valid_2   = vld_s[1];
  assign collision = collision_r;

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Scoreboard bench: three RAM configurations share one stimulus stream; a
// monitor pops expected strobes (data and cycle) and checks held outputs.
module tb_dual_port_ram_param;

  logic        clk;
  logic        reset;
  logic        en_1, wen_1, en_2, wen_2;
  logic [0:1]  be_1, be_2;
  logic [0:9]  addr_1, addr_2;
  logic [0:15] d_in_1, d_in_2;
  logic [0:15] dout1 [3];
  logic [0:15] dout2 [3];
  logic        val1  [3];
  logic        val2  [3];
  logic        col   [3];

  typedef struct {
    int          idx;
    logic [15:0] data;
    bit          chk;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] held    [9];
  bit          held_ok [9];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  // m0: read-first, no out reg; m1: write-first, out reg; m2: no-change, no out reg
  dual_port_ram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .BYTE_WIDTH(8), .RDW_MODE(0), .OUT_REG(0)) u_m0 (
    .clk(clk), .reset(reset),
    .en_1(en_1), .wen_1(wen_1), .be_1(be_1), .addr_1(addr_1), .d_in_1(d_in_1), .d_out_1(dout1[0]), .valid_1(val1[0]),
    .en_2(en_2), .wen_2(wen_2), .be_2(be_2), .addr_2(addr_2), .d_in_2(d_in_2), .d_out_2(dout2[0]), .valid_2(val2[0]),
    .collision(col[0]));
  dual_port_ram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .BYTE_WIDTH(8), .RDW_MODE(1), .OUT_REG(1)) u_m1 (
    .clk(clk), .reset(reset),
    .en_1(en_1), .wen_1(wen_1), .be_1(be_1), .addr_1(addr_1), .d_in_1(d_in_1), .d_out_1(dout1[1]), .valid_1(val1[1]),
    .en_2(en_2), .wen_2(wen_2), .be_2(be_2), .addr_2(addr_2), .d_in_2(d_in_2), .d_out_2(dout2[1]), .valid_2(val2[1]),
    .collision(col[1]));
  dual_port_ram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .BYTE_WIDTH(8), .RDW_MODE(2), .OUT_REG(0)) u_m2 (
    .clk(clk), .reset(reset),
    .en_1(en_1), .wen_1(wen_1), .be_1(be_1), .addr_1(addr_1), .d_in_1(d_in_1), .d_out_1(dout1[2]), .valid_1(val1[2]),
    .en_2(en_2), .wen_2(wen_2), .be_2(be_2), .addr_2(addr_2), .d_in_2(d_in_2), .d_out_2(dout2[2]), .valid_2(val2[2]),
    .collision(col[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string nm(input int i);
    if (i < 6) return $sformatf("rd_m%0d_p%0d", i / 2, i % 2 + 1);
    else       return $sformatf("col_m%0d", i - 6);
  endfunction

  // Monitor: samples 1 time unit after each falling edge and after reset rises.
  always @(negedge clk or posedge reset) begin
    logic [15:0] ad;
    logic        av;
    int          f;
    #1;
    for (int i = 0; i < 9; i++) begin
      if (i < 6) begin
        ad = (i % 2 == 0) ? dout1[i / 2] : dout2[i / 2];
        av = (i % 2 == 0) ? val1[i / 2] : val2[i / 2];
      end else begin
        ad = 16'h0000;
        av = col[i - 6];
      end
      if (reset) begin
        held[i]    = 16'h0000;
        held_ok[i] = (i < 6);
      end
      if (av === 1'b1) begin
        f = -1;
        foreach (q[j]) if (f < 0 && q[j].idx == i) f = j;
        checks++;
        if (f < 0) begin
          errors++;
          $display("FAIL %s: unexpected strobe at cycle %0d (data %h)", nm(i), cyc, ad);
        end else begin
          if (q[f].cyc != cyc) begin
            errors++;
            $display("FAIL %s: strobe at cycle %0d, required cycle %0d", nm(i), cyc, q[f].cyc);
          end else if (q[f].chk && ad !== q[f].data) begin
            errors++;
            $display("FAIL %s: data %h, required %h (cycle %0d)", nm(i), ad, q[f].data, cyc);
          end
          held[i]    = q[f].data;
          held_ok[i] = q[f].chk && (i < 6);
          q.delete(f);
        end
      end else if (av !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL %s: strobe is %b at cycle %0d, required 0", nm(i), av, cyc);
      end else if (i < 6 && held_ok[i]) begin
        checks++;
        if (ad !== held[i]) begin
          errors++;
          $display("FAIL %s_hold: data %h, required held %h (cycle %0d)", nm(i), ad, held[i], cyc);
        end
      end
    end
    for (int j = q.size() - 1; j >= 0; j--) begin
      if (q[j].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: missing strobe due at cycle %0d (now %0d)", nm(q[j].idx), q[j].cyc, cyc);
        q.delete(j);
      end
    end
  end

  task automatic p1(input logic e, input logic w, input logic [1:0] b, input logic [9:0] a, input logic [15:0] d);
    en_1 = e; wen_1 = w; be_1 = b; addr_1 = a; d_in_1 = d;
  endtask

  task automatic p2(input logic e, input logic w, input logic [1:0] b, input logic [9:0] a, input logic [15:0] d);
    en_2 = e; wen_2 = w; be_2 = b; addr_2 = a; d_in_2 = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic [15:0] d, input bit c, input int at);
    exp_t e;
    e.idx = idx; e.data = d; e.chk = c; e.cyc = at;
    q.push_back(e);
  endtask

  // m1 has the output register, so its strobe lands one edge later.
  task automatic exp_rd(input int m, input int p, input logic [15:0] d, input bit c);
    push(m * 2 + p - 1, d, c, cyc + 1 + ((m == 1) ? 1 : 0));
  endtask

  task automatic exp_rd_all(input int p, input logic [15:0] d);
    for (int m = 0; m < 3; m++) exp_rd(m, p, d, 1'b1);
  endtask

  // Same-port write: m0 returns the old word, m1 the merged word, m2 nothing.
  task automatic exp_wr(input int p, input logic [15:0] pre, input bit pre_ok,
                        input logic [15:0] post, input bit post_ok);
    exp_rd(0, p, pre, pre_ok);
    exp_rd(1, p, post, post_ok);
  endtask

  task automatic exp_col();
    for (int m = 0; m < 3; m++) push(6 + m, 16'h0000, 1'b0, cyc + 1);
  endtask

  initial begin
    reset = 1'b1;
    p1(1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
    p2(1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    p1(1'b1, 1'b1, 2'b11, 10'h3FF, 16'hA5C3); exp_wr(1, 16'h0000, 1'b0, 16'hA5C3, 1'b1); tick();
    p1(1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
    p2(1'b1, 1'b0, 2'b00, 10'h3FF, 16'h0000); exp_rd_all(2, 16'hA5C3); tick();
    p2(1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
    p1(1'b1, 1'b1, 2'b11, 10'h005, 16'h1234); exp_wr(1, 16'h0000, 1'b0, 16'h1234, 1'b1); tick();
    p1(1'b1, 1'b1, 2'b01, 10'h005, 16'hFFFF); exp_wr(1, 16'h1234, 1'b1, 16'h12FF, 1'b1); tick();
    p1(1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
    p2(1'b1, 1'b0, 2'b00, 10'h005, 16'h0000); exp_rd_all(2, 16'h12FF); tick();
    p2(1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
    p1(1'b1, 1'b1, 2'b11, 10'h007, 16'h0011); exp_wr(1, 16'h0000, 1'b0, 16'h0011, 1'b1); tick();
    p1(1'b1, 1'b1, 2'b11, 10'h007, 16'h2233); exp_wr(1, 16'h0011, 1'b1, 16'h2233, 1'b1); tick();
    p1(1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
    p2(1'b1, 1'b1, 2'b11, 10'h007, 16'h4455); exp_wr(2, 16'h2233, 1'b1, 16'h4455, 1'b1); tick();

    // Dual write to one address: port 1 owns the high lane, port 2 the low lane.
    p1(1'b1, 1'b1, 2'b10, 10'h009, 16'hAAAA);
    p2(1'b1, 1'b1, 2'b11, 10'h009, 16'h5555);
    exp_wr(1, 16'h0000, 1'b0, 16'h0000, 1'b0);
    exp_wr(2, 16'h0000, 1'b0, 16'h0000, 1'b0);
    exp_col(); tick();
    p1(1'b1, 1'b0, 2'b00, 10'h009, 16'h0000);
    p2(1'b1, 1'b0, 2'b00, 10'h009, 16'h0000);
    exp_rd_all(1, 16'hAA55); exp_rd_all(2, 16'hAA55); tick();

    p2(1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
    p1(1'b1, 1'b1, 2'b11, 10'h003, 16'hBEEF); exp_wr(1, 16'h0000, 1'b0, 16'hBEEF, 1'b1); tick();
    p1(1'b1, 1'b0, 2'b00, 10'h003, 16'h0000);
    p2(1'b1, 1'b0, 2'b00, 10'h003, 16'h0000);
    exp_rd_all(1, 16'hBEEF); exp_rd_all(2, 16'hBEEF); tick();
    p1(1'b1, 1'b1, 2'b11, 10'h003, 16'h1111);
    exp_rd_all(2, 16'hBEEF); exp_wr(1, 16'hBEEF, 1'b1, 16'h1111, 1'b1); exp_col(); tick();
    p1(1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
    exp_rd_all(2, 16'h1111); tick();
    p1(1'b1, 1'b0, 2'b00, 10'h009, 16'h0000);
    p2(1'b1, 1'b1, 2'b01, 10'h009, 16'h0F0F);
    exp_rd_all(1, 16'hAA55); exp_wr(2, 16'hAA55, 1'b1, 16'hAA0F, 1'b1); exp_col(); tick();

    // Disabled ports: no write, no strobe, no collision.
    p1(1'b0, 1'b1, 2'b11, 10'h009, 16'h0000);
    p2(1'b0, 1'b1, 2'b11, 10'h009, 16'hFFFF); tick();
    p2(1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
    p1(1'b1, 1'b0, 2'b00, 10'h009, 16'h0000); exp_rd_all(1, 16'hAA0F); tick();

    p1(1'b1, 1'b0, 2'b00, 10'h3FF, 16'h0000); exp_rd_all(1, 16'hA5C3); tick();
    p1(1'b1, 1'b0, 2'b00, 10'h005, 16'h0000); exp_rd_all(1, 16'h12FF); tick();
    p1(1'b1, 1'b0, 2'b00, 10'h007, 16'h0000); exp_rd_all(1, 16'h4455); tick();

    p1(1'b1, 1'b1, 2'b11, 10'h014, 16'h0102);
    p2(1'b1, 1'b0, 2'b00, 10'h009, 16'h0000);
    exp_wr(1, 16'h0000, 1'b0, 16'h0102, 1'b1); exp_rd_all(2, 16'hAA0F); tick();

    // Reset with a read still inside m1's output pipeline.
    p2(1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
    p1(1'b1, 1'b0, 2'b00, 10'h3FF, 16'h0000);
    exp_rd(0, 1, 16'hA5C3, 1'b1); exp_rd(2, 1, 16'hA5C3, 1'b1); tick();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    p1(1'b1, 1'b1, 2'b11, 10'h005, 16'hDEAD); tick();
    reset = 1'b0;
    p1(1'b0, 1'b0, 2'b00, 10'h000, 16'h0000); tick();
    p2(1'b1, 1'b0, 2'b00, 10'h005, 16'h0000); exp_rd_all(2, 16'h12FF); tick();
    p2(1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
    p1(1'b1, 1'b0, 2'b00, 10'h3FF, 16'h0000); exp_rd_all(1, 16'hA5C3); tick();
    p1(1'b0, 1'b0, 2'b00, 10'h000, 16'h0000);
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
